// File: rtl/vend_change_dispenser.sv
// Refund payout engine: pays a requested NT$ amount from 50/10/5 coin tubes, largest coin first.
// Optional CHANGE_7SEG_EN adds a 3-digit multiplexed display of the amount still owed.
module vend_change_dispenser #(
  parameter int ACK_TIMEOUT = 200,
  parameter int GAP_CYCLES  = 4,
  parameter int INV_INIT    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refund_req,
  input  logic [7:0] refund_amt,
  input  logic       restock,
  input  logic       hopper_ack,
  output logic       eject_50,
  output logic       eject_10,
  output logic       eject_5,
  output logic       busy,
  output logic       done,
  output logic       short_pay,
  output logic       fault,
  output logic [7:0] remain
`ifdef CHANGE_7SEG_EN
  ,
  output logic [3:0] DIGIT,
  output logic [7:0] DISPLAY
`endif
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH, FAULT} state_t;
  typedef enum logic [1:0] {COIN_50, COIN_10, COIN_5} coin_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [5:0] INV_FULL = 6'(INV_INIT);

  state_t        state;
  coin_t         coin;
  logic [CW-1:0] ack_cnt;
  logic [GW-1:0] gap_cnt;
  logic [5:0]    inv50, inv10, inv5;
  logic          restock_pend;
  logic [7:0]    coin_amt;
  logic [7:0]    req_amt;

  // Amounts below a 5 coin can never be paid, so the residue is dropped on capture.
  assign req_amt = refund_amt - (refund_amt % 8'd5);

  always_comb begin
    coin_amt = 8'd5;
    case (coin)
      COIN_50: coin_amt = 8'd50;
      COIN_10: coin_amt = 8'd10;
      default: coin_amt = 8'd5;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      coin         <= COIN_5;
      ack_cnt      <= '0;
      gap_cnt      <= '0;
      inv50        <= INV_FULL;
      inv10        <= INV_FULL;
      inv5         <= INV_FULL;
      restock_pend <= 1'b0;
      remain       <= 8'd0;
      eject_50     <= 1'b0;
      eject_10     <= 1'b0;
      eject_5      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      short_pay    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      done      <= 1'b0;
      short_pay <= 1'b0;

      // A coin in flight must be accounted against the old count, so EJECT defers restock.
      if (restock && state != EJECT) begin
        inv50 <= INV_FULL;
        inv10 <= INV_FULL;
        inv5  <= INV_FULL;
      end

      case (state)
        IDLE: begin
          if (refund_req) begin
            remain <= req_amt;
            busy   <= 1'b1;
            if (req_amt == 8'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end
        end

        SELECT: begin
          ack_cnt <= '0;
          if (remain == 8'd0) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (remain >= 8'd50 && inv50 != 6'd0) begin
            coin     <= COIN_50;
            eject_50 <= 1'b1;
            state    <= EJECT;
          end else if (remain >= 8'd10 && inv10 != 6'd0) begin
            coin     <= COIN_10;
            eject_10 <= 1'b1;
            state    <= EJECT;
          end else if (inv5 != 6'd0) begin
            coin    <= COIN_5;
            eject_5 <= 1'b1;
            state   <= EJECT;
          end else begin
            state     <= FINISH;
            done      <= 1'b1;
            short_pay <= 1'b1;
          end
        end

        EJECT: begin
          if (restock) restock_pend <= 1'b1;
          if (hopper_ack) begin
            eject_50     <= 1'b0;
            eject_10     <= 1'b0;
            eject_5      <= 1'b0;
            remain       <= remain - coin_amt;
            restock_pend <= 1'b0;
            gap_cnt      <= '0;
            state        <= GAP;
            if (restock || restock_pend) begin
              inv50 <= INV_FULL;
              inv10 <= INV_FULL;
              inv5  <= INV_FULL;
            end else begin
              case (coin)
                COIN_50: if (inv50 != 6'd0) inv50 <= inv50 - 6'd1;
                COIN_10: if (inv10 != 6'd0) inv10 <= inv10 - 6'd1;
                default: if (inv5 != 6'd0) inv5 <= inv5 - 6'd1;
              endcase
            end
          end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
            eject_50     <= 1'b0;
            eject_10     <= 1'b0;
            eject_5      <= 1'b0;
            fault        <= 1'b1;
            restock_pend <= 1'b0;
            state        <= FAULT;
            if (restock || restock_pend) begin
              inv50 <= INV_FULL;
              inv10 <= INV_FULL;
              inv5  <= INV_FULL;
            end
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= SELECT;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        FAULT: begin
          if (restock) begin
            fault  <= 1'b0;
            busy   <= 1'b0;
            remain <= 8'd0;
            state  <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CHANGE_7SEG_EN
  logic [15:0] scan_div;
  logic [1:0]  scan_sel;
  logic [7:0]  hund, tens, ones;
  logic [3:0]  cur_digit;

  assign hund = remain / 8'd100;
  assign tens = (remain / 8'd10) % 8'd10;
  assign ones = remain % 8'd10;

  always_comb begin
    cur_digit = ones[3:0];
    case (scan_sel)
      2'd0:    cur_digit = ones[3:0];
      2'd1:    cur_digit = tens[3:0];
      default: cur_digit = hund[3:0];
    endcase
  end

  // Active-high gfedcba pattern; inverted at the pin.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_div <= 16'd0;
      scan_sel <= 2'd0;
      DIGIT    <= 4'hF;
      DISPLAY  <= 8'hFF;
    end else begin
      scan_div <= scan_div + 16'd1;
      if (scan_div == 16'hFFFF) scan_sel <= (scan_sel == 2'd2) ? 2'd0 : scan_sel + 2'd1;
      DIGIT   <= ~(4'b0001 << scan_sel);
      DISPLAY <= {1'b1, ~(fault ? 7'b1110001 : seg7(cur_digit))};
    end
  end
`else
  // Without the display, remain is the only view of the amount still owed.
`endif

endmodule
